y86_data_mem_responder: RTL and testbench

//  Data-memory responder for the y86-64 SEQ core. It is the slave end of the memory-stage access
//  (address = valE, write data = valA, read data -> valM, dmem_error).
//  It accepts one 8-byte little-endian read or write per request, waits a fixed latency, then

---
 rtl/y86_data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_y86_data_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_data_mem_responder.sv
// y86_data_mem_responder
//   Memory-stage data-memory slave for the y86-64 SEQ core. It accepts one 8-byte
//   little-endian read or write per request. After a fixed latency it returns the read
//   data and an out-of-range error flag. Only one transaction is in flight at a time.
//
// Parameters
//   MEM_BYTES  byte-addressed storage size; legal quadword addresses are 0..MEM_BYTES-8
//   LATENCY    wait cycles between request accept and response (0..15)
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset (storage contents are kept)
//   req_valid  request present           req_ready  high only while idle
//   req_write  1 = write, 0 = read       req_addr   byte address (valE), may be unaligned
//   req_wdata  write data (valA)         rsp_valid  response available
//   rsp_ready  response consumed         rsp_rdata  read data (valM), 0 for writes/errors
//   rsp_error  address out of range      busy       transaction in progress
module y86_data_mem_responder #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int unsigned AddrW = $clog2(MEM_BYTES);
  localparam logic [3:0]  Lat   = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic [7:0]  mem_q [MEM_BYTES];

  logic             in_idle;
  logic             cur_write;
  logic [63:0]      cur_addr;
  logic [63:0]      cur_wdata;
  logic             cur_err;
  logic [AddrW-1:0] cur_base;
  logic [63:0]      rd_word;
  logic             enter_resp;
  logic             commit_wr;

  assign in_idle = (state_q == StIdle);

  // With zero latency the RESP entry edge is the accept edge itself, so the live request
  // fields are used; otherwise the copies latched at accept time.
  assign cur_write = in_idle ? req_write : wr_q;
  assign cur_addr  = in_idle ? req_addr  : addr_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;

  // 65-bit compare so addresses near 2^64 cannot wrap into the legal range.
  assign cur_err  = ({1'b0, cur_addr} + 65'd8) > 65'(MEM_BYTES);
  assign cur_base = cur_addr[AddrW-1:0];

  assign enter_resp = (in_idle && req_valid && (Lat == 4'd0)) ||
                      ((state_q == StWait) && (cnt_q == 4'd1));

  // A commit edge that coincides with rst is dropped.
  assign commit_wr = enter_resp && !rst && cur_write && !cur_err;

  always_comb begin
    rd_word = '0;
    if (!cur_err && !cur_write) begin
      for (int i = 0; i < 8; i++) begin
        rd_word[8*i +: 8] = mem_q[cur_base + AddrW'(i)];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[cur_base + AddrW'(i)] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            wr_q      <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (Lat == 4'd0) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_word;
              rsp_error <= cur_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= Lat;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_word;
            rsp_error <= cur_err;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_error <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_data_mem_responder.sv
// Bench for y86_data_mem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=0.
// A transaction-level model predicts every output each cycle; directed sequences add
// literal expectations.
module tb_y86_data_mem_responder;

  localparam int unsigned MemBytes = 1024;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]       req_valid, req_write, rsp_ready;
  logic [1:0][63:0] req_addr, req_wdata;
  logic [1:0]       req_ready, rsp_valid, rsp_error, busy;
  logic [1:0][63:0] rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  y86_data_mem_responder #(.MEM_BYTES(MemBytes), .LATENCY(2)) u_dut_l2 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_write (req_write[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_error (rsp_error[0]),
    .busy      (busy[0])
  );

  y86_data_mem_responder #(.MEM_BYTES(MemBytes), .LATENCY(0)) u_dut_l0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_write (req_write[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_error (rsp_error[1]),
    .busy      (busy[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_pend [2];
  bit          m_vis  [2];
  int          m_rem  [2];
  bit          m_wr   [2];
  logic [63:0] m_a    [2];
  logic [63:0] m_d    [2];
  logic [63:0] m_rd   [2];
  logic [63:0] m_mask [2];
  bit          m_err  [2];
  logic [7:0]  mm     [2][MemBytes];
  bit          kn     [2][MemBytes];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic model_commit(input int k);
    int base;
    m_err[k]  = !(m_a[k] <= 64'(MemBytes - 8));
    m_rd[k]   = '0;
    m_mask[k] = '1;
    if (!m_err[k]) begin
      base = int'(m_a[k]);
      for (int i = 0; i < 8; i++) begin
        if (m_wr[k]) begin
          mm[k][base+i] = m_d[k][8*i +: 8];
          kn[k][base+i] = 1'b1;
        end else begin
          m_rd[k][8*i +: 8] = mm[k][base+i];
          if (!kn[k][base+i]) m_mask[k][8*i +: 8] = 8'h00;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0;
      m_vis[k]  = 1'b0;
      m_rem[k]  = 0;
      m_rd[k]   = '0;
      m_mask[k] = '1;
      m_err[k]  = 1'b0;
      for (int j = 0; j < int'(MemBytes); j++) kn[k][j] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_pend[k] = 1'b0;
          m_vis[k]  = 1'b0;
        end else if (!m_pend[k]) begin
          if (req_valid[k]) begin
            m_pend[k] = 1'b1;
            m_wr[k]   = req_write[k];
            m_a[k]    = req_addr[k];
            m_d[k]    = req_wdata[k];
            m_rem[k]  = lat_of(k);
            if (m_rem[k] == 0) begin
              model_commit(k);
              m_vis[k] = 1'b1;
            end
          end
        end else if (!m_vis[k]) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            model_commit(k);
            m_vis[k] = 1'b1;
          end
        end else if (rsp_ready[k]) begin
          m_pend[k] = 1'b0;
          m_vis[k]  = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("req_ready[%0d]", k), 64'(req_ready[k]), 64'(!m_pend[k]));
          chk($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_pend[k]));
          chk($sformatf("rsp_valid[%0d]", k), 64'(rsp_valid[k]), 64'(m_vis[k]));
          if (m_vis[k]) begin
            chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k] & m_mask[k], m_rd[k] & m_mask[k]);
            chk($sformatf("rsp_error[%0d]", k), 64'(rsp_error[k]), 64'(m_err[k]));
          end else begin
            chk($sformatf("idle_rdata[%0d]", k), rsp_rdata[k], 64'd0);
            chk($sformatf("idle_error[%0d]", k), 64'(rsp_error[k]), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic txn(input int k, input bit wr, input logic [63:0] a, input logic [63:0] d,
                     input int hold, output logic [63:0] rd, output bit er, output int lat);
    int n;
    @(negedge clk);
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk("rsp_timeout", 64'd1, 64'd0);
    rd = rsp_rdata[k];
    er = rsp_error[k];
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid[k]), 64'd1);
      chk("hold_rdata", rsp_rdata[k], rd);
      chk("hold_error", 64'(rsp_error[k]), 64'(er));
      chk("hold_req_ready", 64'(req_ready[k]), 64'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  logic [63:0] rd;
  bit          er;
  int          lat;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready[0]), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("reset_busy", 64'(busy[0]), 64'd0);
    chk("reset_rdata", rsp_rdata[0], 64'd0);

    // Write then read, LATENCY=2
    txn(0, 1'b1, 64'h18, 64'hCAFEBABEDEADBEEF, 0, rd, er, lat);
    txn(0, 1'b1, 64'h10, 64'h1122334455667788, 0, rd, er, lat);
    chk("t1_wr_latency", 64'(lat), 64'd3);
    chk("t1_wr_error", 64'(er), 64'd0);
    chk("t1_wr_rdata", rd, 64'd0);
    txn(0, 1'b0, 64'h10, 64'd0, 0, rd, er, lat);
    chk("t1_rd_10", rd, 64'h1122334455667788);
    chk("t1_model_10", m_rd[0], 64'h1122334455667788);
    txn(0, 1'b0, 64'h11, 64'd0, 0, rd, er, lat);
    chk("t1_rd_11", rd, 64'hEF11223344556677);
    chk("t1_model_11", m_rd[0], 64'hEF11223344556677);

    // Range boundary
    txn(0, 1'b1, 64'h0, 64'h0123456789ABCDEF, 0, rd, er, lat);
    txn(0, 1'b1, 64'h3F8, 64'hFEDCBA9876543210, 0, rd, er, lat);
    txn(0, 1'b0, 64'h3F8, 64'd0, 0, rd, er, lat);
    chk("t2_rd_3f8_err", 64'(er), 64'd0);
    chk("t2_rd_3f8", rd, 64'hFEDCBA9876543210);
    txn(0, 1'b0, 64'h3F9, 64'd0, 0, rd, er, lat);
    chk("t2_rd_3f9_err", 64'(er), 64'd1);
    chk("t2_rd_3f9", rd, 64'd0);
    txn(0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hDEADDEADDEADDEAD, 0, rd, er, lat);
    chk("t2_wr_wrap_err", 64'(er), 64'd1);
    txn(0, 1'b0, 64'h0, 64'd0, 0, rd, er, lat);
    chk("t2_rd_0_after", rd, 64'h0123456789ABCDEF);
    txn(0, 1'b0, 64'h3F8, 64'd0, 0, rd, er, lat);
    chk("t2_rd_3f8_after", rd, 64'hFEDCBA9876543210);

    // Backpressure: response held for 5 cycles
    txn(0, 1'b0, 64'h10, 64'd0, 5, rd, er, lat);
    chk("t3_rd", rd, 64'h1122334455667788);
    chk("t3_req_ready_after", 64'(req_ready[0]), 64'd1);

    // Reset in WAIT drops the write
    txn(0, 1'b1, 64'h20, 64'h5555555555555555, 0, rd, er, lat);
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0]  = 64'h20;
    req_wdata[0] = 64'hAAAAAAAAAAAAAAAA;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("t4_busy_in_wait", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_rsp", 64'(rsp_valid[0]), 64'd0);
    end
    txn(0, 1'b0, 64'h20, 64'd0, 0, rd, er, lat);
    chk("t4_rd_20", rd, 64'h5555555555555555);

    // LATENCY=0 back-to-back with req_valid held high
    @(negedge clk);
    req_write[1] = 1'b1;
    req_addr[1]  = 64'h40;
    req_wdata[1] = 64'h0F0E0D0C0B0A0908;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    chk("t5_T_ready", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    chk("t5_T1_valid", 64'(rsp_valid[1]), 64'd1);
    chk("t5_T1_ready", 64'(req_ready[1]), 64'd0);
    req_write[1] = 1'b0;
    @(negedge clk);
    chk("t5_T2_valid", 64'(rsp_valid[1]), 64'd0);
    chk("t5_T2_ready", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    chk("t5_T3_valid", 64'(rsp_valid[1]), 64'd1);
    chk("t5_T3_rdata", rsp_rdata[1], 64'h0F0E0D0C0B0A0908);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_T4_valid", 64'(rsp_valid[1]), 64'd0);
    chk("t5_T4_busy", 64'(busy[1]), 64'd0);
    rsp_ready[1] = 1'b0;
    txn(1, 1'b0, 64'h40, 64'd0, 2, rd, er, lat);
    chk("t5_l0_latency", 64'(lat), 64'd1);
    chk("t5_l0_rd", rd, 64'h0F0E0D0C0B0A0908);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
